// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch controller with redirect/kill handling (optional trap redirect: FETCH_CTRL_TRAP_EN)
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
`ifdef FETCH_CTRL_TRAP_EN
  ,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
`ifdef FETCH_CTRL_TRAP_EN
  input  logic        trap_valid,
`endif
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_out
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] VALID = 2'd2;

  logic [1:0]  state;
  logic        kill;
  logic [31:0] pending_pc;
  logic        take_redirect;
  logic [31:0] redirect_target;

  // The address bus simply follows the PC register; the PC is frozen while a
  // killed fetch is outstanding, so the address stays stable until the ack.
  assign imem_addr = pc_out;

  // Pick the redirect source for this cycle and word-align the target.
  always_comb begin
    take_redirect   = redirect_valid;
    redirect_target = redirect_pc & ~32'h3;
`ifdef FETCH_CTRL_TRAP_EN
    if (trap_valid) begin
      take_redirect   = 1'b1;
      redirect_target = TRAP_VECTOR & ~32'h3;
    end
`endif
  end

  // Fetch state machine: request, capture or discard, hold for the consumer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      pc_out      <= RESET_PC;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      instr_out   <= 32'h0;
      instr_pc    <= 32'h0;
      kill        <= 1'b0;
      pending_pc  <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          // A stale ack arriving here belongs to an abandoned fetch: ignored.
          if (take_redirect) begin
            pc_out <= redirect_target;
          end
          state       <= REQ;
          imem_req    <= 1'b1;
          instr_valid <= 1'b0;
        end
        REQ: begin
          if (imem_ack) begin
            if (take_redirect) begin
              // Newest redirect beats any pending target; response is dropped.
              pc_out <= redirect_target;
              kill   <= 1'b0;
            end else if (kill) begin
              pc_out <= pending_pc;
              kill   <= 1'b0;
            end else begin
              instr_out   <= imem_rdata;
              instr_pc    <= pc_out;
              pc_out      <= pc_out + 32'd4;
              instr_valid <= 1'b1;
              imem_req    <= 1'b0;
              state       <= VALID;
            end
          end else if (take_redirect) begin
            // Cannot abort the bus transfer; remember where to go afterwards.
            pending_pc <= redirect_target;
            kill       <= 1'b1;
          end
        end
        VALID: begin
          if (take_redirect) begin
            pc_out      <= redirect_target;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= REQ;
          end else if (!stall) begin
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= REQ;
          end
        end
        default: begin
          state       <= IDLE;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
          kill        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - table-driven self-checking bench for fetch_ctrl
module tb_fetch_ctrl;

  typedef struct {
    logic [31:0] rst, stall, rv, rpc, ack, rdata;
    logic [31:0] req, addr, iv, io, ipc, pc;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic [31:0] pc_out;
`ifdef FETCH_CTRL_TRAP_EN
  logic        trap_valid = 1'b0;
`endif

  logic        reset2 = 1'b0;
  logic        ack2 = 1'b0;
  logic [31:0] rdata2 = 32'h0;
  logic        zero1 = 1'b0;
  logic [31:0] zero32 = 32'h0;
  logic        req2;
  logic [31:0] addr2;
  logic        iv2;
  logic [31:0] io2;
  logic [31:0] ipc2;
  logic [31:0] pc2;

  int errors = 0;
  int checks = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  fetch_ctrl u_dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
`ifdef FETCH_CTRL_TRAP_EN
    .trap_valid(trap_valid),
`endif
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .imem_req(imem_req), .imem_addr(imem_addr), .instr_valid(instr_valid),
    .instr_out(instr_out), .instr_pc(instr_pc), .pc_out(pc_out)
  );

  fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .reset(reset2), .stall(zero1),
    .redirect_valid(zero1), .redirect_pc(zero32),
`ifdef FETCH_CTRL_TRAP_EN
    .trap_valid(zero1),
`endif
    .imem_ack(ack2), .imem_rdata(rdata2),
    .imem_req(req2), .imem_addr(addr2), .instr_valid(iv2),
    .instr_out(io2), .instr_pc(ipc2), .pc_out(pc2)
  );

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic row(input logic [31:0] rst, stall_i, rv, rpc, ack, rdata,
                     input logic [31:0] req, addr, iv, io, ipc, pc);
    vec_t v;
    v.rst = rst; v.stall = stall_i; v.rv = rv; v.rpc = rpc; v.ack = ack; v.rdata = rdata;
    v.req = req; v.addr = addr; v.iv = iv; v.io = io; v.ipc = ipc; v.pc = pc;
    tbl.push_back(v);
  endtask

  initial begin
    //   rst stl rv rpc            ack rdata           | req addr           iv io              ipc            pc
    row(0, 0, 0, 32'h0,         0, 32'h0,          0, 32'h0,          0, 32'h0,          32'h0,    32'h0);
    row(1, 0, 0, 32'h0,         0, 32'h0,          1, 32'h0,          0, 32'h0,          32'h0,    32'h0);
    row(1, 0, 0, 32'h0,         0, 32'h0,          1, 32'h0,          0, 32'h0,          32'h0,    32'h0);
    row(1, 0, 0, 32'h0,         1, 32'h1111_0000,  0, 32'h4,          1, 32'h1111_0000,  32'h0,    32'h4);
    row(1, 0, 0, 32'h0,         0, 32'h0,          1, 32'h4,          0, 32'h1111_0000,  32'h0,    32'h4);
    row(1, 0, 0, 32'h0,         1, 32'h1111_0004,  0, 32'h8,          1, 32'h1111_0004,  32'h4,    32'h8);
    row(1, 1, 0, 32'h0,         0, 32'h0,          0, 32'h8,          1, 32'h1111_0004,  32'h4,    32'h8);
    row(1, 1, 0, 32'h0,         0, 32'h0,          0, 32'h8,          1, 32'h1111_0004,  32'h4,    32'h8);
    row(1, 1, 0, 32'h0,         0, 32'h0,          0, 32'h8,          1, 32'h1111_0004,  32'h4,    32'h8);
    row(1, 0, 0, 32'h0,         0, 32'h0,          1, 32'h8,          0, 32'h1111_0004,  32'h4,    32'h8);
    row(1, 0, 0, 32'h0,         0, 32'h0,          1, 32'h8,          0, 32'h1111_0004,  32'h4,    32'h8);
    row(1, 0, 0, 32'h0,         1, 32'h1111_0008,  0, 32'hC,          1, 32'h1111_0008,  32'h8,    32'hC);
    row(1, 0, 0, 32'h0,         0, 32'h0,          1, 32'hC,          0, 32'h1111_0008,  32'h8,    32'hC);
    row(1, 0, 1, 32'h2002,      0, 32'h0,          1, 32'hC,          0, 32'h1111_0008,  32'h8,    32'hC);
    row(1, 0, 0, 32'h0,         0, 32'h0,          1, 32'hC,          0, 32'h1111_0008,  32'h8,    32'hC);
    row(1, 0, 0, 32'h0,         1, 32'hDEAD_BEEF,  1, 32'h2000,       0, 32'h1111_0008,  32'h8,    32'h2000);
    row(1, 0, 0, 32'h0,         1, 32'h2222_0000,  0, 32'h2004,       1, 32'h2222_0000,  32'h2000, 32'h2004);
    row(1, 0, 0, 32'h0,         0, 32'h0,          1, 32'h2004,       0, 32'h2222_0000,  32'h2000, 32'h2004);
    row(1, 0, 1, 32'h40,        0, 32'h0,          1, 32'h2004,       0, 32'h2222_0000,  32'h2000, 32'h2004);
    row(1, 0, 1, 32'h80,        0, 32'h0,          1, 32'h2004,       0, 32'h2222_0000,  32'h2000, 32'h2004);
    row(1, 0, 0, 32'h0,         1, 32'hBAD0_BAD0,  1, 32'h80,         0, 32'h2222_0000,  32'h2000, 32'h80);
    row(1, 0, 0, 32'h0,         1, 32'h2222_0001,  0, 32'h84,         1, 32'h2222_0001,  32'h80,   32'h84);
    row(1, 1, 1, 32'h303,       0, 32'h0,          1, 32'h300,        0, 32'h2222_0001,  32'h80,   32'h300);
    row(1, 0, 1, 32'h600,       1, 32'hBAD0_BAD0,  1, 32'h600,        0, 32'h2222_0001,  32'h80,   32'h600);
    row(1, 0, 0, 32'h0,         1, 32'h2222_0002,  0, 32'h604,        1, 32'h2222_0002,  32'h600,  32'h604);
    row(1, 0, 0, 32'h0,         0, 32'h0,          1, 32'h604,        0, 32'h2222_0002,  32'h600,  32'h604);
    row(0, 0, 0, 32'h0,         0, 32'h0,          0, 32'h0,          0, 32'h0,          32'h0,    32'h0);
    row(1, 0, 0, 32'h0,         1, 32'hBAD0_BAD0,  1, 32'h0,          0, 32'h0,          32'h0,    32'h0);
    row(1, 0, 0, 32'h0,         1, 32'h3333_0000,  0, 32'h4,          1, 32'h3333_0000,  32'h0,    32'h4);
    row(0, 0, 0, 32'h0,         0, 32'h0,          0, 32'h0,          0, 32'h0,          32'h0,    32'h0);
    row(1, 0, 1, 32'h1003,      0, 32'h0,          1, 32'h1000,       0, 32'h0,          32'h0,    32'h1000);
    row(1, 0, 0, 32'h0,         1, 32'h3333_0001,  0, 32'h1004,       1, 32'h3333_0001,  32'h1000, 32'h1004);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      reset          = tbl[i].rst[0];
      stall          = tbl[i].stall[0];
      redirect_valid = tbl[i].rv[0];
      redirect_pc    = tbl[i].rpc;
      imem_ack       = tbl[i].ack[0];
      imem_rdata     = tbl[i].rdata;
      @(posedge clk);
      #1;
      chk("imem_req",    i, {31'h0, imem_req},    tbl[i].req);
      if (tbl[i].req[0]) chk("imem_addr", i, imem_addr, tbl[i].addr);
      chk("instr_valid", i, {31'h0, instr_valid}, tbl[i].iv);
      chk("instr_out",   i, instr_out,            tbl[i].io);
      chk("instr_pc",    i, instr_pc,             tbl[i].ipc);
      chk("pc_out",      i, pc_out,               tbl[i].pc);
    end

`ifdef FETCH_CTRL_TRAP_EN
    // Trap wins over a same-cycle redirect while an instruction is held.
    @(negedge clk);
    stall = 1'b1; imem_ack = 1'b0;
    trap_valid = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h500;
    @(posedge clk);
    #1;
    chk("trap_req",  0, {31'h0, imem_req},    32'h1);
    chk("trap_addr", 0, imem_addr,            32'h100);
    chk("trap_iv",   0, {31'h0, instr_valid}, 32'h0);
    @(negedge clk);
    trap_valid = 1'b0; redirect_valid = 1'b0;
`endif

    // PC wrap: reset at the last word, the second fetch goes to address 0.
    @(negedge clk);
    reset2 = 1'b0;
    @(posedge clk);
    #1;
    chk("wrap_rst_pc", 0, pc2, 32'hFFFF_FFFC);
    chk("wrap_rst_req", 0, {31'h0, req2}, 32'h0);
    @(negedge clk);
    reset2 = 1'b1;
    @(posedge clk);
    #1;
    chk("wrap_req1", 0, {31'h0, req2}, 32'h1);
    chk("wrap_addr1", 0, addr2, 32'hFFFF_FFFC);
    @(negedge clk);
    ack2 = 1'b1; rdata2 = 32'h4444_0000;
    @(posedge clk);
    #1;
    chk("wrap_iv", 0, {31'h0, iv2}, 32'h1);
    chk("wrap_ipc", 0, ipc2, 32'hFFFF_FFFC);
    chk("wrap_io", 0, io2, 32'h4444_0000);
    chk("wrap_pc", 0, pc2, 32'h0);
    @(negedge clk);
    ack2 = 1'b0;
    @(posedge clk);
    #1;
    chk("wrap_req2", 0, {31'h0, req2}, 32'h1);
    chk("wrap_addr2", 0, addr2, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 Parameter TRAP_VECTOR, default 32'h0000_0100, SHALL be the trap target address (used only with FETCH_CTRL_TRAP_EN).
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-low reset.
REQ-005 stall  input  1  SHALL be the consumer hold request: high means the held instruction is not taken.
REQ-006 redirect_valid  input  1  SHALL be the branch/jump redirect strobe.
REQ-007 redirect_pc  input  32  SHALL be the redirect target.
REQ-008 trap_valid  input  1  SHALL be the trap strobe (present only with FETCH_CTRL_TRAP_EN).
REQ-009 imem_ack  input  1  SHALL be the memory completion strobe; imem_rdata is valid in the same cycle.
REQ-010 imem_rdata  input  32  SHALL be the fetched instruction word.
REQ-011 imem_req  output  1  SHALL be the fetch request, held high until imem_ack.
REQ-012 imem_addr  output  32  SHALL be the fetch address, stable while imem_req is high.
REQ-013 instr_valid  output  1  SHALL indicate that instr_out/instr_pc hold a fetched instruction.
REQ-014 instr_out  output  32  SHALL be the held instruction word.
REQ-015 instr_pc  output  32  SHALL be the address of instr_out.
REQ-016 pc_out  output  32  SHALL be the current fetch PC register.

Function
REQ-017 FSM states: IDLE, REQ, VALID; all outputs registered.
REQ-018 IDLE: imem_req=0 and instr_valid=0; next state REQ unconditionally.
REQ-019 REQ: imem_req=1 and imem_addr=pc_out; on imem_ack with no kill and no redirect in that cycle, capture imem_rdata→instr_out and pc_out→instr_pc, set pc_out=pc_out+4, and go to VALID.
REQ-020 VALID: imem_req=0 and instr_valid=1; stall=0 → REQ (new request on the next cycle); stall=1 → stay, outputs unchanged.
REQ-021 Redirect in VALID or IDLE: next cycle instr_valid=0, pc_out=target, state=REQ, so imem_addr=target one cycle after the strobe.
REQ-022 Redirect in REQ without imem_ack: latch target into pending register and set kill=1; imem_addr stays unchanged until imem_ack.
REQ-023 imem_ack while kill=1, or ack coincident with a redirect: discard imem_rdata, instr_valid stays 0, pc_out=target, clear kill; next cycle imem_req=1 with addr=target.
REQ-024 Multiple redirects while kill is pending: the latest target wins.
REQ-025 All targets SHALL have bits[1:0] forced to 0.
REQ-026 PC increment wraps modulo 2^32 (32'hFFFF_FFFC+4 = 32'h0).
REQ-027 instr_valid SHALL never assert for a discarded response; no instruction is ever duplicated or skipped absent a redirect.

Reset
REQ-028 When reset=0 at a clock edge: state=IDLE, pc_out=RESET_PC, imem_req=0, instr_valid=0, instr_out=0, instr_pc=0, kill=0, pending target=0.
REQ-029 Reset mid-request SHALL abandon the outstanding fetch; an imem_ack arriving after reset releases while in IDLE SHALL be ignored.

Configuration
REQ-030 Macro FETCH_CTRL_TRAP_EN defined: trap_valid port exists and behaves as a redirect to TRAP_VECTOR, with priority over redirect_valid in the same cycle.
REQ-031 FETCH_CTRL_TRAP_EN undefined: no trap_valid port and no TRAP_VECTOR logic; only redirect_valid redirects.

Verification
REQ-032 Reset release, ack one cycle after each request → imem_addr sequence 0x0, 0x4, 0x8; instr_pc matches; instr_valid high one cycle each.
REQ-033 stall=1 for 3 cycles in VALID → instr_out/instr_pc held, imem_req=0 throughout; REQ re-entered the cycle after stall drops.
REQ-034 Redirect to 0x0000_2002 in REQ, ack 2 cycles later → data discarded, instr_valid=0, next imem_addr=0x0000_2000.
REQ-035 Redirect to 0x40 then 0x80 during one outstanding fetch → only 0x80 is fetched next.
REQ-036 RESET_PC=0xFFFF_FFFC → second fetch address is 0x0.
REQ-037 With FETCH_CTRL_TRAP_EN, trap_valid and redirect_valid (0x500) in the same cycle → next imem_addr=0x100.
